// File: rtl/level_pkg.sv
// Shared tile codes, background geometry and tracker FSM states for the level logic.
package level_pkg;

  localparam int GRID_W          = 17;
  localparam int GRID_H          = 12;
  localparam int BLOCK_WIDTH     = 40;
  localparam int CHARACTER_WIDTH = 42;
  localparam int SCORE_MAX       = 9999;

  localparam logic [7:0] BDR = 8'd0;
  localparam logic [7:0] SKY = 8'd1;
  localparam logic [7:0] BLK = 8'd2;
  localparam logic [7:0] GND = 8'd3;
  localparam logic [7:0] TKN = 8'd4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    WON   = 2'd2
  } state_t;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + 5'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/coin_hit_detect.sv
// Strict-overlap test between Mario's box and one coin tile; shared edges are not contact.
module coin_hit_detect
  import level_pkg::*;
#(
  parameter int GRID_COLS = GRID_W,
  parameter int GRID_ROWS = GRID_H,
  parameter int TILE_PX   = BLOCK_WIDTH,
  parameter int MARIO_PX  = CHARACTER_WIDTH
) (
  input  logic [4:0]         coin_x,
  input  logic [4:0]         coin_y,
  input  logic signed [31:0] mario_x,
  input  logic signed [31:0] mario_y,
  output logic               hit
);

  logic signed [31:0] w_left, w_top;

  // Grid columns count right-to-left and rows bottom-to-top.
  assign w_left = (GRID_COLS - 1 - int'(coin_x)) * TILE_PX;
  assign w_top  = (GRID_ROWS - 1 - int'(coin_y)) * TILE_PX;

  assign hit = (mario_x < w_left + TILE_PX) && (mario_x + MARIO_PX > w_left) &&
               (mario_y < w_top  + TILE_PX) && (mario_y + MARIO_PX > w_top);

endmodule

// File: rtl/level_coin_tracker.sv
// Coin collection tracker: touch detection, erase handshake queue, win FSM.
// Define LEVEL_COIN_SCORE_EN to build the saturating score accumulator.
module level_coin_tracker #(
  parameter int         NUM_COINS       = 3,
  parameter int         GRID_W          = level_pkg::GRID_W,
  parameter int         GRID_H          = level_pkg::GRID_H,
  parameter int         BLOCK_WIDTH     = level_pkg::BLOCK_WIDTH,
  parameter int         CHARACTER_WIDTH = level_pkg::CHARACTER_WIDTH,
  parameter logic [7:0] SKY             = level_pkg::SKY,
  parameter int         COIN_VALUE      = 100
) (
  input  logic                       vga_clock,
  input  logic                       reset,
  input  logic                       level_start,
  input  logic [NUM_COINS-1:0][4:0]  coin_x,
  input  logic [NUM_COINS-1:0][4:0]  coin_y,
  input  logic signed [31:0]         mario_x,
  input  logic signed [31:0]         mario_y,
  output logic [NUM_COINS-1:0]       collected,
  output logic [4:0]                 coins_remaining,
  output logic                       erase_valid,
  input  logic                       erase_ready,
  output logic [4:0]                 erase_x,
  output logic [4:0]                 erase_y,
  output logic [7:0]                 erase_tile,
  output logic [15:0]                score,
  output logic                       win
);

  localparam int IDX_W = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1;

  logic [NUM_COINS-1:0] w_hit, w_accept, w_clear;
  logic [NUM_COINS-1:0] r_col, r_pend;
  logic [4:0]           r_rem, w_acc_cnt;
  logic [IDX_W-1:0]     w_low_idx, w_sel, r_hold_idx;
  logic [4:0]           r_hold_x, r_hold_y;
  logic                 r_hold, w_xfer;
  level_pkg::state_t    r_state, w_next;

  for (genvar g = 0; g < NUM_COINS; g++) begin : g_coin
    coin_hit_detect #(
      .GRID_COLS (GRID_W),
      .GRID_ROWS (GRID_H),
      .TILE_PX   (BLOCK_WIDTH),
      .MARIO_PX  (CHARACTER_WIDTH)
    ) u_hit (
      .coin_x  (coin_x[g]),
      .coin_y  (coin_y[g]),
      .mario_x (mario_x),
      .mario_y (mario_y),
      .hit     (w_hit[g])
    );
  end

  assign w_accept  = w_hit & ~r_col;
  assign w_acc_cnt = level_pkg::popcount16(16'(w_accept));

  always_comb begin
    w_low_idx = '0;
    for (int i = NUM_COINS - 1; i >= 0; i--)
      if (r_pend[i]) w_low_idx = IDX_W'(i);
  end

  // A stalled offer keeps its coin even if a lower-index coin becomes pending.
  assign w_sel       = r_hold ? r_hold_idx : w_low_idx;
  assign erase_valid = |r_pend;
  assign w_xfer      = erase_valid & erase_ready;
  assign erase_tile  = SKY;

  always_comb begin
    w_clear = '0;
    if (w_xfer) w_clear[w_sel] = 1'b1;
  end

  always_comb begin
    erase_x = '0;
    erase_y = '0;
    if (erase_valid) begin
      if (r_hold) begin
        erase_x = r_hold_x;
        erase_y = r_hold_y;
      end else begin
        erase_x = coin_x[w_low_idx];
        erase_y = coin_y[w_low_idx];
      end
    end
  end

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      r_col      <= '0;
      r_pend     <= '0;
      r_rem      <= 5'(NUM_COINS);
      r_hold     <= 1'b0;
      r_hold_idx <= '0;
      r_hold_x   <= '0;
      r_hold_y   <= '0;
    end else if (level_start) begin
      r_col      <= '0;
      r_pend     <= '0;
      r_rem      <= 5'(NUM_COINS);
      r_hold     <= 1'b0;
    end else begin
      r_col  <= r_col | w_accept;
      r_pend <= (r_pend & ~w_clear) | w_accept;
      r_rem  <= (r_rem > w_acc_cnt) ? r_rem - w_acc_cnt : '0;
      r_hold <= erase_valid & ~erase_ready;
      if (erase_valid && !erase_ready && !r_hold) begin
        r_hold_idx <= w_low_idx;
        r_hold_x   <= coin_x[w_low_idx];
        r_hold_y   <= coin_y[w_low_idx];
      end
    end
  end

  assign collected       = r_col;
  assign coins_remaining = r_rem;

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) r_state <= level_pkg::RUN;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (level_start) w_next = level_pkg::RUN;
    else begin
      case (r_state)
        level_pkg::RUN:   if (r_rem == '0)  w_next = level_pkg::DRAIN;
        level_pkg::DRAIN: if (r_pend == '0) w_next = level_pkg::WON;
        default:          w_next = level_pkg::WON;
      endcase
    end
  end

  always_comb begin
    win = (r_state == level_pkg::WON);
  end

`ifdef LEVEL_COIN_SCORE_EN
  logic [15:0] r_score;
  logic [31:0] w_score_sum;

  assign w_score_sum = 32'(r_score) + 32'(COIN_VALUE) * 32'(w_acc_cnt);

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset)           r_score <= '0;
    else if (level_start) r_score <= '0;
    else if (w_score_sum > 32'(level_pkg::SCORE_MAX)) r_score <= 16'(level_pkg::SCORE_MAX);
    else                  r_score <= w_score_sum[15:0];
  end

  assign score = r_score;
`else
  assign score = '0;
`endif

endmodule
